// File: rtl/accel_bus_master.sv
// Register-bus initiator: turns a header+payload byte stream into peripheral writes/reads.
// Optional macro ACCEL_BUS_MASTER_AUTOINC_EN: advance the register address after every beat.
module accel_bus_master #(
    parameter int READ_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [3:0] address,
    output logic       data_write,
    output logic [7:0] data_in,
    input  logic [7:0] data_out,
    output logic       busy
);

    localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WSTROBE,
        RWAIT,
        RSEND
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] address_q, address_d;
    logic [3:0] cur_addr_q, cur_addr_d;
    logic [3:0] beats_q, beats_d;
    logic [3:0] wait_q, wait_d;
    logic       data_write_q, data_write_d;
    logic [7:0] data_in_q, data_in_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;

    logic       cmd_fire;
    logic       rsp_fire;
    logic       last_beat;
    logic [3:0] next_addr;
    logic [3:0] hdr_beats;

`ifdef ACCEL_BUS_MASTER_AUTOINC_EN
    assign next_addr = cur_addr_q + 4'd1;
`else
    assign next_addr = cur_addr_q;
`endif

    // The reset term keeps the command port closed while the block is held in reset.
    assign cmd_ready  = rst_n && ((state_q == IDLE) || (state_q == WDATA));
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign rsp_fire   = rsp_valid_q && rsp_ready;
    assign last_beat  = (beats_q == 4'd1);
    assign hdr_beats  = {1'b0, cmd_data[6:4]} + 4'd1;

    assign address    = address_q;
    assign data_write = data_write_q;
    assign data_in    = data_in_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        cur_addr_d   = cur_addr_q;
        beats_d      = beats_q;
        wait_d       = wait_q;
        data_write_d = 1'b0;
        data_in_d    = data_in_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    cur_addr_d = cmd_data[3:0];
                    beats_d    = hdr_beats;
                    if (cmd_data[7]) begin
                        state_d = WDATA;
                    end else begin
                        address_d = cmd_data[3:0];
                        wait_d    = WAIT_INIT;
                        state_d   = RWAIT;
                    end
                end
            end
            WDATA: begin
                if (cmd_fire) begin
                    data_in_d    = cmd_data;
                    address_d    = cur_addr_q;
                    data_write_d = 1'b1;
                    state_d      = WSTROBE;
                end
            end
            WSTROBE: begin
                beats_d    = beats_q - 4'd1;
                cur_addr_d = next_addr;
                state_d    = last_beat ? IDLE : WDATA;
            end
            RWAIT: begin
                if (wait_q <= 4'd1) begin
                    rsp_data_d  = data_out;
                    rsp_valid_d = 1'b1;
                    state_d     = RSEND;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            RSEND: begin
                if (rsp_fire) begin
                    rsp_valid_d = 1'b0;
                    beats_d     = beats_q - 4'd1;
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cur_addr_d = next_addr;
                        address_d  = next_addr;
                        wait_d     = WAIT_INIT;
                        state_d    = RWAIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            address_q    <= 4'd0;
            cur_addr_q   <= 4'd0;
            beats_q      <= 4'd0;
            wait_q       <= 4'd0;
            data_write_q <= 1'b0;
            data_in_q    <= 8'd0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            cur_addr_q   <= cur_addr_d;
            beats_q      <= beats_d;
            wait_q       <= wait_d;
            data_write_q <= data_write_d;
            data_in_q    <= data_in_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_accel_bus_master.sv
// Self-checking bench for accel_bus_master: directed scenarios, then random commands
// checked against a transaction-level model of the register file.
module tb_accel_bus_master;

    localparam int RW = 1;
`ifdef ACCEL_BUS_MASTER_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] env_mem [16];
    bit         env_init = 1'b0;
    logic [7:0] model_mem [16];
    bit         rand_rdy = 1'b0;

    logic [7:0] cmd_q [$];
    logic [3:0] obs_st_addr [$];
    logic [7:0] obs_st_data [$];
    int         obs_st_cyc [$];
    logic [3:0] obs_rs_addr [$];
    logic [7:0] obs_rs_data [$];
    logic [3:0] exp_st_addr [$];
    logic [7:0] exp_st_data [$];
    logic [3:0] exp_rs_addr [$];
    logic [7:0] exp_rs_data [$];

    accel_bus_master #(.READ_WAIT(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral responder: register file whose power-up contents are 0x40 + index.
    assign data_out = env_mem[address];
    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= 8'(8'h40 + i);
            env_init <= 1'b1;
        end else if (data_write) begin
            env_mem[address] <= data_in;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (data_write) begin
                obs_st_addr.push_back(address);
                obs_st_data.push_back(data_in);
                obs_st_cyc.push_back(cyc);
            end
            if (rsp_valid && rsp_ready) begin
                obs_rs_addr.push_back(address);
                obs_rs_data.push_back(rsp_data);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        obs_st_addr.delete();
        obs_st_data.delete();
        obs_st_cyc.delete();
        obs_rs_addr.delete();
        obs_rs_data.delete();
    endtask

    // Expected bus traffic for the command in cmd_q; only the first beats_done writes land.
    task automatic model_cmd(input int beats_done);
        logic [7:0] hdr;
        int         len;
        int         n;
        logic [3:0] a;
        hdr = cmd_q[0];
        len = int'(hdr[6:4]) + 1;
        n   = hdr[7] ? beats_done : len;
        exp_st_addr.delete();
        exp_st_data.delete();
        exp_rs_addr.delete();
        exp_rs_data.delete();
        for (int i = 0; i < n; i++) begin
            a = AUTOINC ? 4'(int'(hdr[3:0]) + i) : hdr[3:0];
            if (hdr[7]) begin
                exp_st_addr.push_back(a);
                exp_st_data.push_back(cmd_q[i + 1]);
                model_mem[a] = cmd_q[i + 1];
            end else begin
                exp_rs_addr.push_back(a);
                exp_rs_data.push_back(model_mem[a]);
            end
        end
    endtask

    task automatic send_cmd(input int max_gap);
        int g;
        int n;
        foreach (cmd_q[i]) begin
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (g > 0) begin
                cmd_valid = 1'b0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            cmd_valid = 1'b1;
            cmd_data  = cmd_q[i];
            n = 0;
            while (!cmd_ready && n < 1000) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic compare_all();
        chk("strobe_count", obs_st_addr.size(), exp_st_addr.size());
        for (int i = 0; i < exp_st_addr.size() && i < obs_st_addr.size(); i++) begin
            chk($sformatf("strobe_addr[%0d]", i), 32'(obs_st_addr[i]), 32'(exp_st_addr[i]));
            chk($sformatf("strobe_data[%0d]", i), 32'(obs_st_data[i]), 32'(exp_st_data[i]));
        end
        chk("rsp_count", obs_rs_data.size(), exp_rs_data.size());
        for (int i = 0; i < exp_rs_data.size() && i < obs_rs_data.size(); i++) begin
            chk($sformatf("rsp_addr[%0d]", i), 32'(obs_rs_addr[i]), 32'(exp_rs_addr[i]));
            chk($sformatf("rsp_data[%0d]", i), 32'(obs_rs_data[i]), 32'(exp_rs_data[i]));
        end
    endtask

    initial begin
        int         n;
        bit         w;
        int         len;
        logic [7:0] held_data;
        logic [3:0] held_addr;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'(8'h40 + i);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_address", 32'(address), 32'd0);
        chk("reset_data_write", 32'(data_write), 32'd0);
        chk("reset_data_in", 32'(data_in), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Two-beat write with back-to-back payload
        cmd_q = '{8'h93, 8'hA5, 8'h5A};
        model_cmd(2);
        clear_obs();
        send_cmd(0);
        wait_idle();
        compare_all();
        if (obs_st_cyc.size() >= 2)
            chk("strobe_spacing", 32'(obs_st_cyc[1] - obs_st_cyc[0]), 32'd2);
        chk("write_done_busy", 32'(busy), 32'd0);
        chk("write_hold_addr", 32'(address), AUTOINC ? 32'd4 : 32'd3);
        chk("write_hold_data", 32'(data_in), 32'h5A);

        // Single read and its latency
        cmd_q = '{8'h02};
        model_cmd(1);
        clear_obs();
        send_cmd(0);
        chk("read_lat_early", 32'(rsp_valid), 32'd0);
        for (int i = 1; i < RW; i++) begin
            @(posedge clk);
            #1;
            chk("read_lat_wait", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("read_lat_valid", 32'(rsp_valid), 32'd1);
        chk("read_lat_data", 32'(rsp_data), 32'h42);
        chk("read_lat_addr", 32'(address), 32'd2);
        wait_idle();
        compare_all();

        // Four-beat read wrapping through address 15
        cmd_q = '{8'h3E};
        model_cmd(4);
        clear_obs();
        send_cmd(0);
        wait_idle();
        compare_all();

        // Response back-pressure
        rsp_ready = 1'b0;
        cmd_q = '{8'h10};
        model_cmd(2);
        clear_obs();
        send_cmd(0);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid_seen", 32'(rsp_valid), 32'd1);
        held_data = exp_rs_data[0];
        held_addr = exp_rs_addr[0];
        repeat (20) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_data", 32'(rsp_data), 32'(held_data));
            chk("stall_address", 32'(address), 32'(held_addr));
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle();
        compare_all();

        // Asynchronous reset in the middle of an eight-beat write
        cmd_q = '{8'hF0, 8'h11, 8'h22, 8'h33};
        model_cmd(2);
        clear_obs();
        send_cmd(0);
        chk("pre_reset_strobe", 32'(data_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_data_write", 32'(data_write), 32'd0);
        chk("mid_reset_address", 32'(address), 32'd0);
        chk("mid_reset_data_in", 32'(data_in), 32'd0);
        chk("mid_reset_busy", 32'(busy), 32'd0);
        chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_reset_cmd_ready", 32'(cmd_ready), 32'd0);
        compare_all();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_q = '{8'h05};
        model_cmd(1);
        clear_obs();
        send_cmd(0);
        wait_idle();
        compare_all();
        if (obs_rs_data.size() >= 1)
            chk("post_reset_read5", 32'(obs_rs_data[0]), 32'h45);

        // Random commands with payload gaps and random response back-pressure
        rand_rdy = 1'b1;
        repeat (40) begin
            w   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            cmd_q.delete();
            cmd_q.push_back({w, 3'(len - 1), 4'($urandom_range(0, 15))});
            if (w) for (int i = 0; i < len; i++) cmd_q.push_back(8'($urandom_range(0, 255)));
            model_cmd(len);
            clear_obs();
            send_cmd(2);
            wait_idle();
            compare_all();
        end
        rand_rdy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/accel_bus_master.md
Name: accel_bus_master

Overview:
Register-bus initiator for the accelerator's 4-bit-address / 8-bit-data peripheral port, i.e. the master side of the bus the accelerator responds on.
- Takes a byte-wide command stream (header + payload) over valid/ready and turns it into single-cycle write strobes or wait-stated reads on the peripheral bus.
- Returns read bytes on a valid/ready response stream.
- Sits between a host link (UART/SPI byte front-end) and the accelerator for bring-up and standalone test.

Parameters:
READ_WAIT, 1, cycles between driving address and sampling data_out on a read; legal 1..15.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
cmd_valid  input  1  command byte valid
cmd_ready  output  1  command byte accepted when cmd_valid && cmd_ready at posedge
cmd_data  input  8  command byte (header or write payload)
rsp_valid  output  1  read response byte valid
rsp_ready  input  1  response consumer ready
rsp_data  output  8  read response byte
address  output  4  peripheral register address
data_write  output  1  single-cycle write strobe
data_in  output  8  write data to peripheral
data_out  input  8  read data from peripheral (combinational in address)
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock/reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, address=0, data_write=0, data_in=0, rsp_valid=0, rsp_data=0, busy=0.
- cmd_ready is forced to 0 while rst_n=0. Otherwise cmd_ready is a pure state decode: 1 in IDLE and WDATA, 0 in all other states.
- Header byte fields: bit7 = W (1 write, 0 read); bits6:4 = LEN-1, so 1..8 beats; bits3:0 = start address.
- States: IDLE, WDATA, WSTROBE, RWAIT, RSEND.
- IDLE:
  - Header accepted with W=1: latch addr and beats; go to WDATA.
  - Header accepted with W=0: address<=addr, load wait counter with READ_WAIT; go to RWAIT.
- WDATA: payload byte accepted -> data_in<=byte, address<=cur_addr, data_write<=1; go to WSTROBE.
- WSTROBE:
  - data_write is high for exactly this one cycle.
  - Next edge: data_write<=0, beats decrement, cur_addr advances per the Optional Feature.
  - beats remaining -> WDATA; none remaining -> IDLE.
  - Minimum 2 cycles per write beat.
- RWAIT:
  - address held stable while the counter decrements each cycle.
  - On the edge where the counter would reach 0: rsp_data<=data_out, rsp_valid<=1; go to RSEND.
  - Read latency: header handshake at edge T -> rsp_valid high after edge T+READ_WAIT.
- RSEND:
  - rsp_valid and rsp_data stay stable until rsp_ready=1.
  - On handshake: rsp_valid<=0, beats decrement.
  - beats remaining -> cur_addr advances, address<=cur_addr, counter reloads, go to RWAIT. Otherwise go to IDLE.
- Outputs when idle: address and data_in hold their last driven values. data_write is never high outside WSTROBE.
- Back-pressure: rsp_ready held low stalls the block indefinitely; no further bus reads are issued.
- cmd_valid low in WDATA waits indefinitely with no strobe.
- Reset mid-operation: immediate return to reset values. A data_write already high is dropped asynchronously; remaining beats and partially received payload are discarded.
- Header bytes never alias payload: in WDATA every accepted byte is payload.

Optional Feature:
Macro ACCEL_BUS_MASTER_AUTOINC_EN.
- Defined: cur_addr increments by 1 after each beat, wrapping modulo 16 (15 -> 0).
- Undefined: cur_addr stays fixed at the header address for all beats (FIFO-style register access).

Test Plan:
1. Write: header 0x93 (W, LEN=2, addr 3), payload 0xA5, 0x5A, cmd_valid always high.
   - data_write pulses twice, 1 cycle each, 2 cycles apart.
   - address/data_in = 3/0xA5 then 4/0x5A with AUTOINC_EN; 3/0x5A without. busy falls after the second strobe.
2. Read with READ_WAIT=1, responder returning 0x40+address: header 0x02, rsp_ready=1.
   - rsp_valid rises after edge T+1 with rsp_data=0x42.
   - data_write stays 0 throughout.
3. Burst read with wrap and AUTOINC_EN: header 0x3E (LEN=4, addr 14).
   - Responses 0x4E, 0x4F, 0x40, 0x41 in order; address sequence 14, 15, 0, 1.
4. Back-pressure: read header 0x10 with rsp_ready=0 for 20 cycles.
   - rsp_valid and rsp_data stable, address unchanged, cmd_ready=0.
   - Raising rsp_ready yields two responses total.
5. Reset mid-write: after header 0xF0 and 3 payload bytes, pulse rst_n low asynchronously between edges.
   - Outputs return to reset values immediately; cmd_ready=1 after release.
   - The next header 0x05 performs a clean single read of address 5.
